// File: rtl/mips_cpu_alu_decode.sv
// rtl/mips_cpu_alu_decode.sv - MIPS32 ALU-op decoder feeding a 2-entry in-order issue buffer
// Instructions are decoded on entry; the buffer holds decoded entries, never raw words.
module mips_cpu_alu_decode (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  alu_op,
  output logic [4:0]  sa,
  output logic [4:0]  src_a_reg,
  output logic [4:0]  src_b_reg,
  output logic [4:0]  dest_reg,
  output logic        b_is_imm,
  output logic [31:0] imm,
  output logic        illegal,
  output logic [15:0] issue_count
);

  typedef struct packed {
    logic [4:0]  alu_op;
    logic [4:0]  sa;
    logic [4:0]  src_a;
    logic [4:0]  src_b;
    logic [4:0]  dest;
    logic        b_is_imm;
    logic [31:0] imm;
    logic        illegal;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t      state_q, state_d;
  entry_t      head_q, head_d;
  entry_t      tail_q, tail_d;
  entry_t      dec;
  entry_t      head_out;
  logic        in_ready_q;
  logic [15:0] issue_count_q;
  logic        push, pop;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm16;
  logic [4:0]  r_op, i_op;
  logic        r_known, i_known, i_sext;

  assign opcode = in_instr[31:26];
  assign rs     = in_instr[25:21];
  assign rt     = in_instr[20:16];
  assign rd     = in_instr[15:11];
  assign shamt  = in_instr[10:6];
  assign funct  = in_instr[5:0];
  assign imm16  = in_instr[15:0];

  always_comb begin
    dec     = '0;
    r_op    = 5'd0;
    r_known = 1'b1;
    i_op    = 5'd0;
    i_known = 1'b1;
    i_sext  = 1'b0;
    case (funct)
      6'h00: r_op = 5'd6;
      6'h02: r_op = 5'd7;
      6'h03: r_op = 5'd8;
      6'h04: r_op = 5'd9;
      6'h06: r_op = 5'd10;
      6'h07: r_op = 5'd11;
      6'h21: r_op = 5'd2;
      6'h23: r_op = 5'd3;
      6'h24: r_op = 5'd0;
      6'h25: r_op = 5'd1;
      6'h26: r_op = 5'd5;
      6'h2B: r_op = 5'd4;
      default: r_known = 1'b0;
    endcase
    case (opcode)
      6'h09: begin i_op = 5'd2; i_sext = 1'b1; end
      6'h0B: begin i_op = 5'd4; i_sext = 1'b1; end
      6'h0C: i_op = 5'd0;
      6'h0D: i_op = 5'd1;
      6'h0E: i_op = 5'd5;
      default: i_known = 1'b0;
    endcase

    if (opcode == 6'h00 && r_known) begin
      dec.alu_op = r_op;
      dec.dest   = rd;
      if (r_op >= 5'd6 && r_op <= 5'd8) begin
        dec.src_b = rt;
        dec.sa    = shamt;
      end else if (r_op >= 5'd9 && r_op <= 5'd11) begin
        // variable shifts: the ALU shifts operand a by b[4:0]
        dec.src_a = rt;
        dec.src_b = rs;
      end else begin
        dec.src_a = rs;
        dec.src_b = rt;
      end
    end else if (i_known) begin
      dec.alu_op   = i_op;
      dec.src_a    = rs;
      dec.dest     = rt;
      dec.b_is_imm = 1'b1;
      dec.imm      = i_sext ? {{16{imm16[15]}}, imm16} : {16'h0000, imm16};
    end else begin
      dec.illegal = 1'b1;
    end
  end

  assign out_valid = (state_q != EMPTY);
  assign push      = in_valid & in_ready_q;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      EMPTY: if (push) begin
        head_d  = dec;
        state_d = ONE;
      end
      ONE: begin
        if (push && pop) begin
          head_d = dec;
        end else if (push) begin
          tail_d  = dec;
          state_d = TWO;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: if (pop) begin
        head_d  = tail_q;
        state_d = ONE;
      end
      default: state_d = EMPTY;
    endcase
  end

  // in_ready is registered from the next state so out_ready never reaches it combinationally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= EMPTY;
      head_q        <= '0;
      tail_q        <= '0;
      in_ready_q    <= 1'b0;
      issue_count_q <= 16'h0000;
    end else begin
      state_q       <= state_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      in_ready_q    <= (state_d != TWO);
      issue_count_q <= issue_count_q + {15'h0000, pop};
    end
  end

  assign head_out    = out_valid ? head_q : '0;
  assign in_ready    = in_ready_q;
  assign alu_op      = head_out.alu_op;
  assign sa          = head_out.sa;
  assign src_a_reg   = head_out.src_a;
  assign src_b_reg   = head_out.src_b;
  assign dest_reg    = head_out.dest;
  assign b_is_imm    = head_out.b_is_imm;
  assign imm         = head_out.imm;
  assign illegal     = head_out.illegal;
  assign issue_count = issue_count_q;

endmodule

// File: tb/tb_mips_cpu_alu_decode.sv
// tb/tb_mips_cpu_alu_decode.sv - scoreboard bench for mips_cpu_alu_decode
// Stimulus pushes expected entries from a table-driven model; a negedge monitor pops and compares.
module tb_mips_cpu_alu_decode;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [4:0]  alu_op, sa, src_a_reg, src_b_reg, dest_reg;
  logic        b_is_imm, illegal;
  logic [31:0] imm;
  logic [15:0] issue_count;

  mips_cpu_alu_decode dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .alu_op(alu_op), .sa(sa),
    .src_a_reg(src_a_reg), .src_b_reg(src_b_reg), .dest_reg(dest_reg),
    .b_is_imm(b_is_imm), .imm(imm), .illegal(illegal), .issue_count(issue_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  op;
    logic [4:0]  sa;
    logic [4:0]  a;
    logic [4:0]  b;
    logic [4:0]  d;
    logic        bimm;
    logic [31:0] imm;
    logic        ill;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass = 0;
  logic [15:0] exp_cnt = 16'h0;
  logic        last_acc = 1'b0;

  int r_fn [12] = '{'h00, 'h02, 'h03, 'h04, 'h06, 'h07, 'h21, 'h23, 'h24, 'h25, 'h26, 'h2B};
  int r_op [12] = '{6, 7, 8, 9, 10, 11, 2, 3, 0, 1, 5, 4};
  int i_opc [5] = '{'h09, 'h0B, 'h0C, 'h0D, 'h0E};
  int i_op  [5] = '{2, 4, 0, 1, 5};
  int i_sx  [5] = '{1, 1, 0, 0, 0};

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic exp_t model(input logic [31:0] w);
    exp_t e;
    int   op6, fn, rs, rt, rd, sh;
    e   = '0;
    e.ill = 1'b1;
    op6 = int'(w[31:26]);
    fn  = int'(w[5:0]);
    rs  = int'(w[25:21]);
    rt  = int'(w[20:16]);
    rd  = int'(w[15:11]);
    sh  = int'(w[10:6]);
    if (op6 == 0) begin
      for (int k = 0; k < 12; k++) if (r_fn[k] == fn) begin
        e.ill = 1'b0;
        e.op  = 5'(r_op[k]);
        e.d   = 5'(rd);
        if (r_op[k] >= 6 && r_op[k] <= 8)       begin e.b = 5'(rt); e.sa = 5'(sh); end
        else if (r_op[k] >= 9 && r_op[k] <= 11) begin e.a = 5'(rt); e.b = 5'(rs); end
        else                                    begin e.a = 5'(rs); e.b = 5'(rt); end
      end
    end else begin
      for (int k = 0; k < 5; k++) if (i_opc[k] == op6) begin
        e.ill  = 1'b0;
        e.op   = 5'(i_op[k]);
        e.a    = 5'(rs);
        e.d    = 5'(rt);
        e.bimm = 1'b1;
        e.imm  = (i_sx[k] != 0) ? 32'($signed(w[15:0])) : 32'(w[15:0]);
      end
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 2))
      0: begin
        w[31:26] = 6'h00;
        if ($urandom_range(0, 3) != 0) w[5:0] = 6'(r_fn[$urandom_range(0, 11)]);
      end
      1: w[31:26] = 6'(i_opc[$urandom_range(0, 4)]);
      default: ;
    endcase
    return w;
  endfunction

  // inputs change 1 after posedge; acceptance is decided 7 after posedge, after the monitor ran
  task automatic drive(input logic v, input logic [31:0] w, input logic r);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_instr  = w;
    out_ready = r;
    #6;
    last_acc = v && in_ready;
    if (last_acc) sb.push_back(model(w));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sb.delete();
    exp_cnt   = 16'h0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_issue_count", issue_count, 0);
    check("rst_in_ready", in_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("in_ready_before_edge", in_ready, 0);
    drive(0, 0, 0);
    check("in_ready_after_edge", in_ready, 1);
  endtask

  task automatic one_shot(input logic [31:0] w, input logic [4:0] op, input logic [4:0] a,
                          input logic [4:0] b, input logic [4:0] d, input logic [4:0] s,
                          input logic bi, input logic [31:0] im, input logic il,
                          input logic [15:0] cnt);
    drive(1, w, 0);
    drive(0, 0, 0);
    check("dir_out_valid", out_valid, 1);
    check("dir_alu_op", alu_op, op);
    check("dir_src_a", src_a_reg, a);
    check("dir_src_b", src_b_reg, b);
    check("dir_dest", dest_reg, d);
    check("dir_sa", sa, s);
    check("dir_b_is_imm", b_is_imm, bi);
    check("dir_imm", imm, im);
    check("dir_illegal", illegal, il);
    drive(0, 0, 1);
    drive(0, 0, 0);
    check("dir_issue_count", issue_count, cnt);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      check("mon_rst_valid", out_valid, 0);
      check("mon_rst_count", issue_count, 0);
      check("mon_rst_fields", {alu_op, sa, src_a_reg, src_b_reg, dest_reg, b_is_imm, imm, illegal}, 0);
    end else begin
      check("mon_issue_count", issue_count, exp_cnt);
      check("mon_out_valid", out_valid, sb.size() != 0);
      if (out_valid && sb.size() != 0) begin
        check("mon_alu_op", alu_op, sb[0].op);
        check("mon_sa", sa, sb[0].sa);
        check("mon_src_a", src_a_reg, sb[0].a);
        check("mon_src_b", src_b_reg, sb[0].b);
        check("mon_dest", dest_reg, sb[0].d);
        check("mon_b_is_imm", b_is_imm, sb[0].bimm);
        check("mon_imm", imm, sb[0].imm);
        check("mon_illegal", illegal, sb[0].ill);
        if (out_ready) begin
          void'(sb.pop_front());
          exp_cnt = exp_cnt + 16'h1;
        end
      end else if (!out_valid) begin
        check("mon_idle_fields", {alu_op, sa, src_a_reg, src_b_reg, dest_reg, b_is_imm, imm, illegal}, 0);
      end
    end
  end

  initial begin
    #2;
    do_reset();

    one_shot(32'h00851021, 5'd2, 5'd4, 5'd5, 5'd2, 5'd0, 1'b0, 32'h0, 1'b0, 16'd1);
    one_shot(32'h00021080, 5'd6, 5'd0, 5'd2, 5'd2, 5'd2, 1'b0, 32'h0, 1'b0, 16'd2);
    one_shot(32'h00A41006, 5'd10, 5'd4, 5'd5, 5'd2, 5'd0, 1'b0, 32'h0, 1'b0, 16'd3);
    one_shot(32'h3421FFFF, 5'd1, 5'd1, 5'd0, 5'd1, 5'd0, 1'b1, 32'h0000FFFF, 1'b0, 16'd4);
    one_shot(32'h2402FFFF, 5'd2, 5'd0, 5'd0, 5'd2, 5'd0, 1'b1, 32'hFFFFFFFF, 1'b0, 16'd5);
    one_shot(32'h8C000000, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 1'b1, 16'd6);

    // backpressure: two accepted, third refused until the head drains
    drive(1, 32'h00851021, 0);
    check("fill_acc1", last_acc, 1);
    drive(1, 32'h3421FFFF, 0);
    check("fill_acc2", last_acc, 1);
    drive(1, 32'h00A41006, 0);
    check("full_in_ready", in_ready, 0);
    check("full_head_op", alu_op, 2);
    drive(1, 32'h00A41006, 0);
    check("stall_head_op", alu_op, 2);
    check("stall_head_src_a", src_a_reg, 4);
    last_acc = 1'b0;
    for (int k = 0; k < 4 && !last_acc; k++) drive(1, 32'h00A41006, 1);
    check("third_accepted", last_acc, 1);
    repeat (3) drive(0, 0, 1);
    check("drain_empty", sb.size(), 0);

    // reset while holding two entries
    drive(1, 32'h8C000000, 0);
    drive(1, 32'h00851021, 0);
    drive(0, 0, 0);
    check("two_held", in_ready, 0);
    do_reset();

    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) do_reset();
      drive($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 2) != 0);
    end
    repeat (4) drive(0, 0, 1);
    check("final_drain", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mips_cpu_alu_decode.md
MIPS_CPU_ALU_DECODE -- requirements
Module: mips_cpu_alu_decode

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port in_valid, input, 1 bit: in_instr is valid this cycle.
REQ-004 SHALL have port in_ready, output, 1 bit: block accepts an instruction this cycle.
REQ-005 SHALL have port in_instr, input, 32 bits: MIPS32 instruction word.
REQ-006 SHALL have port out_valid, output, 1 bit: head entry is presented to the ALU issue stage.
REQ-007 SHALL have port out_ready, input, 1 bit: consumer takes the head entry this cycle.
REQ-008 SHALL have port alu_op, output, 5 bits: ALU op code (0 AND, 1 OR, 2 ADD, 3 SUB, 4 SLT unsigned, 5 XOR, 6 SLL, 7 SRL, 8 SRA, 9 SLLV, 10 SRLV, 11 SRAV).
REQ-009 SHALL have ports sa (output, 5 bits, shift amount), src_a_reg and src_b_reg (outputs, 5 bits each, register indices for ALU operands a/b), and dest_reg (output, 5 bits, writeback index).
REQ-010 SHALL have ports b_is_imm (output, 1 bit: ALU b is imm, not src_b_reg) and imm (output, 32 bits: extended immediate).
REQ-011 SHALL have ports illegal (output, 1 bit: unsupported encoding) and issue_count (output, 16 bits: handshakes completed on out side).

Function
REQ-012 SHALL decode R-type (opcode 0x00) by funct: 0x00->6, 0x02->7, 0x03->8, 0x04->9, 0x06->10, 0x07->11, 0x21->2, 0x23->3, 0x24->0, 0x25->1, 0x26->5, 0x2B->4; dest_reg=rd, b_is_imm=0.
REQ-013 SHALL, for R-type non-shifts, drive src_a_reg=rs, src_b_reg=rt, sa=0.
REQ-014 SHALL, for fixed shifts (6,7,8), drive src_a_reg=0, src_b_reg=rt, sa=instr[10:6].
REQ-015 SHALL, for variable shifts (9,10,11), drive src_a_reg=rt, src_b_reg=rs, sa=0 (ALU shifts a by b[4:0]).
REQ-016 SHALL decode I-type: 0x09 ADDIU->2 sign-extend, 0x0B SLTIU->4 sign-extend, 0x0C ANDI->0, 0x0D ORI->1, 0x0E XORI->5 zero-extend; src_a_reg=rs, src_b_reg=0, dest_reg=rt, b_is_imm=1, sa=0.
REQ-017 SHALL, for any other encoding, set illegal=1, alu_op=0, dest_reg=0, all other fields 0; the entry is still queued and issued in order.
REQ-018 SHALL drive imm=0 whenever b_is_imm=0.
REQ-019 SHALL decode at input and store decoded entries in a 2-entry in-order buffer; states EMPTY, ONE, TWO.
REQ-020 SHALL drive in_ready=1 in EMPTY and ONE, 0 in TWO (registered, no combinational path from out_ready).
REQ-021 SHALL define push=in_valid&in_ready, pop=out_valid&out_ready; EMPTY+push->ONE; ONE+push&!pop->TWO; ONE+pop&!push->EMPTY; ONE+push&pop->ONE (new entry becomes head); TWO+pop->ONE; otherwise hold.
REQ-022 SHALL give latency of one cycle: an instruction accepted in EMPTY is on outputs with out_valid=1 the next cycle.
REQ-023 SHALL drive out_valid=1 exactly in ONE and TWO; head fields SHALL remain stable while out_valid=1 and out_ready=0.
REQ-024 SHALL drive all decoded outputs to 0 when out_valid=0.
REQ-025 SHALL increment issue_count by 1 on every pop, wrapping 0xFFFF->0x0000.

Reset
REQ-026 SHALL, while rst_n=0, force state EMPTY, in_ready=0, out_valid=0, issue_count=0, all decoded outputs 0; entries discarded.
REQ-027 SHALL raise in_ready on the first rising clk edge after rst_n deasserts; reset mid-transfer SHALL drop buffered entries without issuing.

Verification
REQ-028 SHALL cover: push 0x00851021, out_ready=1 -> next cycle alu_op=2, src_a_reg=4, src_b_reg=5, dest_reg=2, b_is_imm=0, issue_count=1 after pop.
REQ-029 SHALL cover: push 0x00021080 -> alu_op=6, sa=2, src_a_reg=0, src_b_reg=2, dest_reg=2; push 0x00A41006 -> alu_op=10, src_a_reg=4, src_b_reg=5, sa=0.
REQ-030 SHALL cover: push 0x3421FFFF -> alu_op=1, imm=0x0000FFFF, dest_reg=1; push 0x2402FFFF -> alu_op=2, imm=0xFFFFFFFF, dest_reg=2.
REQ-031 SHALL cover: out_ready=0, in_valid=1 for 3 instructions -> two accepted, in_ready=0 after second, head stable; out_ready=1 -> order preserved, third accepted.
REQ-032 SHALL cover: push 0x8C000000 (LW) -> illegal=1, alu_op=0, issued in order; rst_n=0 with TWO entries -> out_valid=0, issue_count=0 immediately.
